cordic_angle_prep: RTL
======================

Name: cordic_angle_prep

Overview:
- Upstream stage of the pipelined CORDIC rotator.
- Accepts a full-circle angle in binary angle measure (BAM) and folds it into the core's convergence range [-pi/2, +pi/2].
- Converts the folded angle to the core's signed Q2.14 radian format (pi/4 = 0x3244 nominal) and records a result-negation flag.
- Delays that flag so it lines up with the core's sine/cosine outputs, for the downstream sign fix.

Parameters:
- N, 16, data width of angle in/out (design and test at 16 only).
- LAT, 16, CORDIC core latency in cycles; depth of the flag delay line (>=1).
- HALF_PI, 16'h6488, pi/2 in unsigned Q2.14 (25736), used as conversion multiplier.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- in_angle  input  N  BAM angle, unsigned, 0x0000..0xFFFF = [0, 2pi)
- in_valid  input  1  in_angle valid
- in_ready  output  1  stage can accept
- out_angle  output  N  folded angle, signed Q2.14 radians, to core init_angle
- out_valid  output  1  out_angle valid
- out_ready  input  1  core/consumer accepts out_angle
- out_neg  output  1  negate flag travelling with out_angle
- flag_neg  output  1  negate flag delayed LAT cycles after acceptance
- flag_valid  output  1  flag_neg valid strobe (one cycle per accepted sample)

Behaviour:
- Reset (rst=0, async): all stage registers, valids and the flag delay line clear. out_angle=0, out_valid=0, out_neg=0, flag_neg=0, flag_valid=0. in_ready=1 once reset is released.
- Stage 1 (fold), loaded on in_valid && in_ready:
  - s = in_angle as signed.
  - If -16384 <= s <= 16383: a1 = s, neg = 0.
  - Otherwise: a1 = in_angle + 0x8000 (mod 2^16, i.e. subtract pi), neg = 1.
  - Exact boundaries: 0x4000 folds (neg=1); 0xC000 passes (neg=0).
- Stage 2 (scale): p = a1 (signed 16) * HALF_PI (unsigned 16), 32-bit signed. out_angle = (p + 2^13) >>> 14, arithmetic shift, truncated to N bits. The result always lies in [-25736, +25736]; no saturation is needed.
- Latency: 2 cycles from accept to out_valid when there is no backpressure.
- Pipeline handshake:
  - Stage 2 loads when it is empty or out_ready=1.
  - Stage 1 advances when stage 2 loads.
  - in_ready = !s1_valid || stage 1 advancing (combinational from out_ready is allowed).
  - Throughput is 1 sample/cycle with out_ready held high.
  - While out_valid=1 && out_ready=0, out_angle and out_neg hold stable. Samples are never dropped or duplicated.
- Flag delay line:
  - LAT-deep shift register of {valid, neg}; it shifts every cycle and never stalls, because the core is free-running.
  - The entry pushed each cycle is {out_valid && out_ready, out_neg}.
  - flag_valid/flag_neg appear exactly LAT cycles after the accepting edge.
- Simultaneous events: accept and emit in the same cycle are both honoured.
- Reset mid-operation: in-flight samples and pending flags are discarded; no flag_valid pulses occur after reset.

Test Plan:
- Zero: in_angle=0x0000 with out_ready=1 -> 2 cycles later out_angle=0x0000, out_neg=0; LAT cycles after acceptance, flag_valid=1 with flag_neg=0.
- Quadrant values (expected out_angle, out_neg):
  - 0x2000 -> 0x3244, 0
  - 0x4000 -> 0x9B78, 1
  - 0xA000 -> 0x3244, 1
  - 0xC000 -> 0x9B78, 0
  - 0xE000 -> 0xCDBC, 0
  - 0x8000 -> 0x0000, 1
- Streaming: 20 back-to-back samples with out_ready=1 -> in_ready stays 1; outputs are in order, one per cycle; flag_valid shows 20 consecutive pulses starting LAT cycles after the first accept.
- Backpressure: hold out_ready=0 for 4 cycles during a stream -> in_ready drops after both stages fill; out_angle stays stable; no sample is lost or repeated after release; flag pulses occur only for accepted cycles.
- Reset mid-stream: assert rst=0 asynchronously between clock edges with 3 samples in flight -> all outputs read 0 immediately; after release, no stale out_valid or flag_valid appears.
- LAT=1 build: flag_valid follows acceptance by exactly 1 cycle.

Source files
------------

// File: rtl/cordic_angle_prep.sv
// Front end of the CORDIC rotator: folds a BAM angle into [-pi/2, +pi/2], rescales it to
// signed Q2.14 radians, and delays the result-negation flag to line up with the core outputs.
module cordic_angle_prep #(
  parameter int          N       = 16,
  parameter int          LAT     = 16,
  parameter logic [15:0] HALF_PI = 16'h6488
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_angle,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_angle,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_neg,
  output logic         flag_neg,
  output logic         flag_valid
);

  localparam int PW   = 2 * N + 1;
  localparam int FRAC = 14;
  localparam logic signed [PW-1:0] ROUND_HALF = PW'(1) << (FRAC - 1);

  logic                 s1_valid_r;
  logic [N-1:0]         a1_r;
  logic                 s1_neg_r;
  logic [LAT-1:0]       fv_r;
  logic [LAT-1:0]       fn_r;

  logic                 s2_load_s;
  logic                 accept_s;
  logic                 fold_s;
  logic [N-1:0]         a1_s;
  logic signed [PW-1:0] prod_s;
  logic signed [PW-1:0] rnd_s;

  // Handshake, fold decision and Q2.14 scaling
  always_comb begin
    s2_load_s = !out_valid || out_ready;
    in_ready  = !s1_valid_r || s2_load_s;
    accept_s  = in_valid && in_ready;
    // In range exactly when the two top bits agree; folding subtracts pi by flipping the MSB.
    fold_s    = in_angle[N-1] ^ in_angle[N-2];
    if (fold_s) begin
      a1_s = in_angle ^ {1'b1, {(N-1){1'b0}}};
    end else begin
      a1_s = in_angle;
    end
    prod_s = $signed({{(N+1){a1_r[N-1]}}, a1_r}) * $signed({{(N+1){1'b0}}, HALF_PI});
    rnd_s  = prod_s + ROUND_HALF;
  end

  // Stage 1: folded angle and negate flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_r <= 1'b0;
      a1_r       <= {N{1'b0}};
      s1_neg_r   <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      a1_r       <= a1_s;
      s1_neg_r   <= fold_s;
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2: scaled output register, held stable under backpressure
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_angle <= {N{1'b0}};
      out_neg   <= 1'b0;
    end else if (s2_load_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_angle <= N'(rnd_s >>> FRAC);
        out_neg   <= s1_neg_r;
      end
    end
  end

  // Free-running flag delay line; the core never stalls so neither does this
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fv_r <= {LAT{1'b0}};
      fn_r <= {LAT{1'b0}};
    end else begin
      fv_r[0] <= out_valid && out_ready;
      fn_r[0] <= out_neg;
      for (int i = 1; i < LAT; i++) begin
        fv_r[i] <= fv_r[i-1];
        fn_r[i] <= fn_r[i-1];
      end
    end
  end

  assign flag_valid = fv_r[LAT-1];
  assign flag_neg   = fn_r[LAT-1];

endmodule
